serial_deser_rx: RTL and testbench
==================================

Name: serial_deser_rx

Overview:
- Receiving end of a single-bit serial stream, as produced by a bit-per-clock driver into a D-input.
- Samples one qualified serial bit per clock and assembles WIDTH-bit words.
- Presents each word on a parallel output with a valid/ready handshake.
- Uses one shift register plus one output holding register, so reception continues while a completed word waits; overrun and framing errors are reported as sticky flags.

Parameters:
- WIDTH, 8, bits per word; legal range 2..32.
- MSB_FIRST, 1, 1 = first received bit lands in dout[WIDTH-1]; 0 = first bit lands in dout[0].

Ports:
- clk  input  1  single clock; all state updates on the rising edge.
- reset_n  input  1  asynchronous, active-low reset.
- sin  input  1  serial data bit.
- sin_valid  input  1  sin is sampled on this edge only when high.
- sin_sof  input  1  start of frame; qualified by sin_valid; marks the current bit as bit 0 of a new word.
- dout  output  WIDTH  completed word.
- dout_valid  output  1  dout holds an unconsumed word.
- dout_ready  input  1  consumer accepts dout when dout_valid && dout_ready.
- bit_cnt  output  $clog2(WIDTH+1)  number of bits currently held in the partial word.
- overrun  output  1  sticky: a completed word was dropped.
- frame_err  output  1  sticky: sof arrived with a partial word pending.
- err_clr  input  1  clears overrun and frame_err.

Behaviour:
- Reset (reset_n low, asynchronous): shift register, dout, dout_valid, bit_cnt, overrun and frame_err all go to 0. Any partial word is discarded. Reset mid-word or mid-handshake loses the data with no flag set.
- Receive FSM states: IDLE (bit_cnt==0) and SHIFT (bit_cnt 1..WIDTH-1).
- Accepted bit (sin_valid=1):
  - MSB_FIRST=1: shift left, inserting sin at the LSB.
  - MSB_FIRST=0: shift right, inserting sin at the MSB.
  - bit_cnt increments.
- sin_valid=0: no state change; sin and sin_sof are ignored.
- Word completion: the accepted bit that makes the count reach WIDTH completes the word.
  - bit_cnt returns to 0 (IDLE) on that same edge.
  - The completed word is a candidate for the output register on that same edge.
- Latency: dout and dout_valid update on the edge that samples the last bit, so they are visible one cycle after the last bit is presented.
- Output register states: EMPTY (dout_valid=0) and FULL (dout_valid=1).
  - EMPTY + completion: load the word, go to FULL.
  - FULL + dout_ready=1 with no completion: go to EMPTY. dout holds its last value; its content is don't-care while invalid.
  - FULL + dout_ready=1 + completion on the same edge: load the new word, stay FULL. No overrun.
  - FULL + dout_ready=0 + completion: drop the new word, keep the old dout, set overrun.
- dout is stable while dout_valid=1 and dout_ready=0.
- SOF handling (sin_valid=1 and sin_sof=1):
  - Any partial bits are discarded.
  - The current bit is stored as bit 0 of a new word and bit_cnt becomes 1.
  - If bit_cnt was nonzero before that edge, set frame_err.
  - SOF in IDLE is legal and sets no flag.
  - SOF on what would otherwise be the completing bit: the old partial word is discarded (it does not complete), frame_err is set, and the new word starts.
- Error flags:
  - err_clr=1 clears both flags.
  - If a set event and err_clr occur on the same edge, set wins.

Test Plan:
- Basic word: WIDTH=8, MSB_FIRST=1. Reset, then present bits 1,0,1,0,0,1,0,1 with sin_valid=1 and dout_ready=0.
  -> dout=0xA5 and dout_valid=1 on the 8th edge; bit_cnt=0 after it.
  -> dout holds until dout_ready=1, then dout_valid drops next edge.
- LSB-first: MSB_FIRST=0, same 8 bits -> dout=0xA5 bit-reversed = 0xA5 (palindrome check fails); use bits 1,1,0,0,0,0,0,0 -> dout=0x03.
- Gaps: same 0xA5 bits with sin_valid=0 for 3 cycles between bits 4 and 5 (sin toggling during the gap).
  -> dout=0xA5; bit_cnt stays 4 during the gap.
- Overrun and back-to-back: send 0x3C, hold dout_ready=0, send 0xC3.
  -> dout stays 0x3C and overrun=1.
  -> Repeat with dout_ready=1 asserted on the completing edge of 0xC3: dout=0xC3, dout_valid stays 1, overrun stays 0 (after err_clr).
- SOF framing: send 3 bits, then SOF with 0x81 bits.
  -> frame_err=1 and dout=0x81 after 8 bits from the SOF.
  -> SOF as the first bit after reset leaves frame_err=0.
- Reset mid-operation: assert reset_n=0 asynchronously (between clock edges) after 5 bits with dout_valid=1.
  -> All outputs are 0 immediately.
  -> The next 8 bits form a clean word.

Source files
------------

// File: rtl/serial_deser_rx.sv
`default_nettype none
// ============================================================================
// Module   : serial_deser_rx
// Purpose  : Serial-to-parallel receiver. Samples one qualified serial bit per
//            clock, assembles WIDTH-bit words in a shift register and hands
//            each completed word to a single output holding register with a
//            valid/ready handshake. Reception continues while a completed
//            word waits. Dropped words and broken frames raise sticky flags.
// Ports    : clk         - rising-edge clock
//            reset_n     - asynchronous active-low reset
//            sin         - serial data bit
//            sin_valid   - qualifies sin / sin_sof on this edge
//            sin_sof     - current bit is bit 0 of a new word
//            dout        - completed word
//            dout_valid  - dout holds an unconsumed word
//            dout_ready  - consumer accepts dout when valid && ready
//            bit_cnt     - bits held in the partial word
//            overrun     - sticky: a completed word was dropped
//            frame_err   - sticky: sof arrived with a partial word pending
//            err_clr     - clears overrun and frame_err
// Revision : 1.0 - initial release
// ============================================================================
module serial_deser_rx #(
  parameter int WIDTH     = 8,
  parameter bit MSB_FIRST = 1'b1
) (
  input  logic                         clk,
  input  logic                         reset_n,
  input  logic                         sin,
  input  logic                         sin_valid,
  input  logic                         sin_sof,
  output logic [WIDTH-1:0]             dout,
  output logic                         dout_valid,
  input  logic                         dout_ready,
  output logic [$clog2(WIDTH+1)-1:0]   bit_cnt,
  output logic                         overrun,
  output logic                         frame_err,
  input  logic                         err_clr
);

  localparam int            CW       = $clog2(WIDTH+1);
  localparam logic [CW-1:0] LAST_CNT = CW'(WIDTH - 1);

  typedef enum logic [0:0] {
    ST_IDLE  = 1'b0,
    ST_SHIFT = 1'b1
  } rx_state_t;

  rx_state_t        state_q,      state_d;
  logic [WIDTH-1:0] shift_q,      shift_d;
  logic [WIDTH-1:0] dout_q,       dout_d;
  logic             dout_valid_q, dout_valid_d;
  logic [CW-1:0]    bit_cnt_q,    bit_cnt_d;
  logic             overrun_q,    overrun_d;
  logic             frame_err_q,  frame_err_d;

  // Shift register contents after accepting sin, and the first-bit image
  // used when a new frame starts.
  logic [WIDTH-1:0] shifted_w;
  logic [WIDTH-1:0] sof_word_w;

  generate
    if (MSB_FIRST) begin : g_msb_first
      assign shifted_w  = {shift_q[WIDTH-2:0], sin};
      assign sof_word_w = {{(WIDTH-1){1'b0}}, sin};
    end else begin : g_lsb_first
      assign shifted_w  = {sin, shift_q[WIDTH-1:1]};
      assign sof_word_w = {sin, {(WIDTH-1){1'b0}}};
    end
  endgenerate

  logic complete;
  logic overrun_set;
  logic frame_set;

  always_comb begin
    state_d      = state_q;
    shift_d      = shift_q;
    dout_d       = dout_q;
    dout_valid_d = dout_valid_q;
    bit_cnt_d    = bit_cnt_q;
    complete     = 1'b0;
    overrun_set  = 1'b0;
    frame_set    = 1'b0;

    // Receive side
    if (sin_valid) begin
      if (sin_sof) begin
        // New frame wins over everything, including a would-be completing bit.
        shift_d   = sof_word_w;
        bit_cnt_d = CW'(1);
        state_d   = ST_SHIFT;
        frame_set = (state_q == ST_SHIFT);
      end else begin
        shift_d = shifted_w;
        if (bit_cnt_q == LAST_CNT) begin
          complete  = 1'b1;
          bit_cnt_d = '0;
          state_d   = ST_IDLE;
        end else begin
          bit_cnt_d = bit_cnt_q + CW'(1);
          state_d   = ST_SHIFT;
        end
      end
    end

    // Output holding register. A consume and a load on the same edge keeps
    // the register full with the new word.
    if (complete) begin
      if (!dout_valid_q || dout_ready) begin
        dout_d       = shifted_w;
        dout_valid_d = 1'b1;
      end else begin
        overrun_set  = 1'b1;
      end
    end else if (dout_valid_q && dout_ready) begin
      dout_valid_d = 1'b0;
    end

    // Sticky flags: a set event on the clearing edge takes priority.
    overrun_d   = overrun_set | (overrun_q   & ~err_clr);
    frame_err_d = frame_set   | (frame_err_q & ~err_clr);
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q      <= ST_IDLE;
      shift_q      <= '0;
      dout_q       <= '0;
      dout_valid_q <= 1'b0;
      bit_cnt_q    <= '0;
      overrun_q    <= 1'b0;
      frame_err_q  <= 1'b0;
    end else begin
      state_q      <= state_d;
      shift_q      <= shift_d;
      dout_q       <= dout_d;
      dout_valid_q <= dout_valid_d;
      bit_cnt_q    <= bit_cnt_d;
      overrun_q    <= overrun_d;
      frame_err_q  <= frame_err_d;
    end
  end

  assign dout       = dout_q;
  assign dout_valid = dout_valid_q;
  assign bit_cnt    = bit_cnt_q;
  assign overrun    = overrun_q;
  assign frame_err  = frame_err_q;

endmodule
`default_nettype wire

// File: tb/tb_serial_deser_rx.sv
`default_nettype none
// ============================================================================
// Module   : tb_serial_deser_rx
// Purpose  : Directed self-checking bench for serial_deser_rx. An MSB-first
//            and an LSB-first instance share all inputs.
// Revision : 1.0 - initial release
// ============================================================================
module tb_serial_deser_rx;

  localparam int WIDTH = 8;
  localparam int CW    = $clog2(WIDTH+1);

  logic             clk;
  logic             reset_n;
  logic             sin;
  logic             sin_valid;
  logic             sin_sof;
  logic             dout_ready;
  logic             err_clr;

  logic [WIDTH-1:0] dout_m,  dout_l;
  logic             dv_m,    dv_l;
  logic [CW-1:0]    cnt_m,   cnt_l;
  logic             ovr_m,   ovr_l;
  logic             fe_m,    fe_l;

  int checks = 0;
  int errors = 0;

  serial_deser_rx #(.WIDTH(WIDTH), .MSB_FIRST(1'b1)) dut (
    .clk(clk), .reset_n(reset_n), .sin(sin), .sin_valid(sin_valid),
    .sin_sof(sin_sof), .dout(dout_m), .dout_valid(dv_m),
    .dout_ready(dout_ready), .bit_cnt(cnt_m), .overrun(ovr_m),
    .frame_err(fe_m), .err_clr(err_clr)
  );

  serial_deser_rx #(.WIDTH(WIDTH), .MSB_FIRST(1'b0)) dut_lsb (
    .clk(clk), .reset_n(reset_n), .sin(sin), .sin_valid(sin_valid),
    .sin_sof(sin_sof), .dout(dout_l), .dout_valid(dv_l),
    .dout_ready(dout_ready), .bit_cnt(cnt_l), .overrun(ovr_l),
    .frame_err(fe_l), .err_clr(err_clr)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  // Present one bit for one edge, then sample 1 time unit after the edge.
  task automatic send_bit(input logic b, input logic sof);
    sin       = b;
    sin_sof   = sof;
    sin_valid = 1'b1;
    @(posedge clk);
    #1;
    sin_valid = 1'b0;
    sin_sof   = 1'b0;
  endtask

  task automatic idle_cycle();
    @(posedge clk);
    #1;
  endtask

  // Send bits [hi:lo] of a word, MSB of the word first on the wire.
  task automatic send_bits(input logic [7:0] w, input int hi, input int lo, input logic sof_first);
    for (int i = hi; i >= lo; i--) begin
      send_bit(w[i], (i == hi) ? sof_first : 1'b0);
    end
  endtask

  task automatic consume();
    dout_ready = 1'b1;
    idle_cycle();
    dout_ready = 1'b0;
  endtask

  initial begin
    reset_n    = 1'b0;
    sin        = 1'b0;
    sin_valid  = 1'b0;
    sin_sof    = 1'b0;
    dout_ready = 1'b0;
    err_clr    = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    check("rst_dout",    {24'd0, dout_m}, 32'h0);
    check("rst_valid",   {31'd0, dv_m},   32'h0);
    check("rst_cnt",     {28'd0, cnt_m},  32'h0);
    check("rst_overrun", {31'd0, ovr_m},  32'h0);
    check("rst_frame",   {31'd0, fe_m},   32'h0);
    reset_n = 1'b1;
    idle_cycle();

    // Basic word 0xA5, MSB first
    send_bits(8'hA5, 7, 4, 1'b0);
    check("basic_cnt4", {28'd0, cnt_m}, 32'd4);
    send_bits(8'hA5, 3, 1, 1'b0);
    check("basic_cnt7",    {28'd0, cnt_m}, 32'd7);
    check("basic_valid7",  {31'd0, dv_m},  32'd0);
    send_bits(8'hA5, 0, 0, 1'b0);
    check("basic_dout",    {24'd0, dout_m}, 32'hA5);
    check("basic_valid",   {31'd0, dv_m},   32'd1);
    check("basic_cnt0",    {28'd0, cnt_m},  32'd0);
    idle_cycle();
    idle_cycle();
    check("basic_hold",    {24'd0, dout_m}, 32'hA5);
    check("basic_holdv",   {31'd0, dv_m},   32'd1);
    consume();
    check("basic_consumed", {31'd0, dv_m},  32'd0);

    // LSB-first: wire bits 1,1,0,0,0,0,0,0
    send_bits(8'hC0, 7, 0, 1'b0);
    check("lsb_dout",  {24'd0, dout_l}, 32'h03);
    check("msb_dout",  {24'd0, dout_m}, 32'hC0);
    consume();

    // Gap of 3 invalid cycles between bits 4 and 5, sin and sof toggling
    send_bits(8'hA5, 7, 4, 1'b0);
    for (int g = 0; g < 3; g++) begin
      sin     = g[0];
      sin_sof = ~g[0];
      idle_cycle();
      check("gap_cnt", {28'd0, cnt_m}, 32'd4);
    end
    sin_sof = 1'b0;
    send_bits(8'hA5, 3, 0, 1'b0);
    check("gap_dout",  {24'd0, dout_m}, 32'hA5);
    check("gap_frame", {31'd0, fe_m},   32'd0);
    consume();

    // Overrun: 0x3C held, 0xC3 dropped
    send_bits(8'h3C, 7, 0, 1'b0);
    send_bits(8'hC3, 7, 0, 1'b0);
    check("ovr_dout",  {24'd0, dout_m}, 32'h3C);
    check("ovr_valid", {31'd0, dv_m},   32'd1);
    check("ovr_flag",  {31'd0, ovr_m},  32'd1);
    err_clr = 1'b1;
    idle_cycle();
    err_clr = 1'b0;
    check("ovr_cleared", {31'd0, ovr_m}, 32'd0);

    // Set and clear on the same edge: set wins
    send_bits(8'h55, 7, 1, 1'b0);
    err_clr = 1'b1;
    send_bits(8'h55, 0, 0, 1'b0);
    err_clr = 1'b0;
    check("ovr_setwins", {31'd0, ovr_m},  32'd1);
    check("ovr_keep",    {24'd0, dout_m}, 32'h3C);
    err_clr = 1'b1;
    idle_cycle();
    err_clr = 1'b0;

    // Back-to-back: consume on the completing edge of 0xC3
    send_bits(8'hC3, 7, 1, 1'b0);
    dout_ready = 1'b1;
    send_bits(8'hC3, 0, 0, 1'b0);
    dout_ready = 1'b0;
    check("b2b_dout",    {24'd0, dout_m}, 32'hC3);
    check("b2b_valid",   {31'd0, dv_m},   32'd1);
    check("b2b_overrun", {31'd0, ovr_m},  32'd0);
    consume();
    check("b2b_empty",   {31'd0, dv_m},   32'd0);

    // SOF framing: 3 stray bits then a framed 0x81
    send_bits(8'hE0, 7, 5, 1'b0);
    check("sof_cnt3",  {28'd0, cnt_m}, 32'd3);
    check("sof_fe0",   {31'd0, fe_m},  32'd0);
    send_bits(8'h81, 7, 7, 1'b1);
    check("sof_fe1",   {31'd0, fe_m},  32'd1);
    check("sof_cnt1",  {28'd0, cnt_m}, 32'd1);
    send_bits(8'h81, 6, 0, 1'b0);
    check("sof_dout",  {24'd0, dout_m}, 32'h81);
    check("sof_valid", {31'd0, dv_m},   32'd1);
    consume();
    err_clr = 1'b1;
    idle_cycle();
    err_clr = 1'b0;
    check("sof_cleared", {31'd0, fe_m}, 32'd0);

    // SOF on the would-be completing bit
    send_bits(8'hFF, 7, 1, 1'b0);
    send_bit(1'b1, 1'b1);
    check("sofc_fe",    {31'd0, fe_m},  32'd1);
    check("sofc_cnt",   {28'd0, cnt_m}, 32'd1);
    check("sofc_nodat", {31'd0, dv_m},  32'd0);
    send_bits(8'h81, 6, 0, 1'b0);
    check("sofc_dout",  {24'd0, dout_m}, 32'h81);

    // Reset mid-word with a word pending
    send_bits(8'h5A, 7, 3, 1'b0);
    check("prerst_valid", {31'd0, dv_m},  32'd1);
    check("prerst_cnt",   {28'd0, cnt_m}, 32'd5);
    #3;
    reset_n = 1'b0;
    #1;
    check("arst_dout",  {24'd0, dout_m}, 32'h0);
    check("arst_valid", {31'd0, dv_m},   32'h0);
    check("arst_cnt",   {28'd0, cnt_m},  32'h0);
    check("arst_fe",    {31'd0, fe_m},   32'h0);
    check("arst_ovr",   {31'd0, ovr_m},  32'h0);
    idle_cycle();
    reset_n = 1'b1;
    idle_cycle();

    // First bit after reset is SOF: legal, no flag
    send_bits(8'h96, 7, 7, 1'b1);
    check("post_fe", {31'd0, fe_m}, 32'd0);
    send_bits(8'h96, 6, 0, 1'b0);
    check("post_dout",    {24'd0, dout_m}, 32'h96);
    check("post_dout_l",  {24'd0, dout_l}, 32'h69);
    check("post_valid",   {31'd0, dv_m},   32'd1);
    check("post_fe_end",  {31'd0, fe_m},   32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
